// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter that shares one uart_tx byte interface among
//            NUM_REQ message sources. A grant is held for a whole message,
//            delimited by req_last, so bytes from different sources never
//            interleave. A watchdog forces release if the granted source
//            stalls (req_valid low) mid-message.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            req_valid/data/last - per-source byte stream (source i on [8i+7:8i])
//            req_ready           - per-source accept
//            tx_valid/data       - byte to uart_tx, tx_ready from uart_tx
//            grant               - one-hot current owner, zero when idle
//            busy                - message in progress
//            timeout_pulse       - one-cycle pulse on watchdog release
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam bit               WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [0:0]         state_q,         state_d;
  logic [NUM_REQ-1:0] grant_q,         grant_d;
  logic [IDX_W-1:0]   last_winner_q,   last_winner_d;
  logic [CNT_W-1:0]   wd_cnt_q,        wd_cnt_d;
  logic               timeout_pulse_q, timeout_pulse_d;

  logic               g_valid;
  logic               g_last;
  logic [IDX_W-1:0]   g_idx;
  logic               xfer;
  logic               winner_found;
  logic [IDX_W-1:0]   winner_idx;

  // Datapath: with grant one-hot (or zero in IDLE), masking the inputs with
  // grant selects the owner's signals and yields zero when nobody owns the bus.
  always_comb begin
    g_valid = |(req_valid & grant_q);
    g_last  = |(req_last & grant_q);
    tx_data = '0;
    g_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        tx_data = tx_data | req_data[8*i +: 8];
        g_idx   = IDX_W'(i);
      end
    end
  end

  assign tx_valid      = g_valid;
  assign req_ready     = grant_q & {NUM_REQ{tx_ready}};
  assign xfer          = g_valid & tx_ready;
  assign grant         = grant_q;
  assign busy          = (state_q == ST_LOCK);
  assign timeout_pulse = timeout_pulse_q;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    winner_found = 1'b0;
    winner_idx   = '0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_winner_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!winner_found && req_valid[cand_idx]) begin
        winner_found = 1'b1;
        winner_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_winner_d   = last_winner_q;
    wd_cnt_d        = wd_cnt_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner_found) begin
          state_d             = ST_LOCK;
          grant_d             = '0;
          grant_d[winner_idx] = 1'b1;
          wd_cnt_d            = '0;
        end
      end
      ST_LOCK: begin
        // Only an absent byte counts; a byte held off by tx_ready does not.
        if (g_valid) begin
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
        if (xfer && g_last) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          last_winner_d = g_idx;
        end else if (WD_EN && !g_valid && (wd_cnt_q == WD_LIMIT)) begin
          state_d         = ST_IDLE;
          grant_d         = '0;
          last_winner_d   = g_idx;
          timeout_pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      last_winner_q   <= IDX_W'(NUM_REQ - 1);
      wd_cnt_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_winner_q   <= last_winner_d;
      wd_cnt_q        <= wd_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=16).
//            Per-source byte queues feed the DUT; expected {source, byte}
//            pairs are queued when stimulus is set up and compared on xfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [NR-1:0] grant;
  logic          busy;
  logic          timeout_pulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (16),
    .CNT_W   (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  // Source byte queues: {last, data}
  logic [8:0]  sq [NR][$];
  // Expected transfers: {source index, data}
  logic [15:0] exp_q[$];

  logic reset_nxt;
  logic tx_ready_nxt;
  logic last_xfer;
  int   n_checks;
  int   n_pass;
  int   n_xfer;
  int   rr1_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh2idx(input logic [NR-1:0] oh);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = NR - 1; i >= 0; i--) begin
      if (oh[i]) r = 8'(i);
    end
    return r;
  endfunction

  task automatic sb_push(input int src, input logic [7:0] data);
    exp_q.push_back({8'(src), data});
  endtask

  task automatic drive();
    logic [8:0] head;
    reset    = reset_nxt;
    tx_ready = tx_ready_nxt;
    for (int i = 0; i < NR; i++) begin
      if (sq[i].size() > 0) begin
        head              = sq[i][0];
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]       = head[8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic sample();
    logic [15:0] e;
    last_xfer = 1'b0;
    if (tx_valid && tx_ready) begin
      last_xfer = 1'b1;
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_xfer", {16'(oh2idx(grant)), 8'h00, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_xfer", {16'h0, oh2idx(grant), tx_data}, {16'h0, e});
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i] && sq[i].size() > 0) begin
        void'(sq[i].pop_front());
      end
    end
    if (req_ready[1]) rr1_cnt++;
  endtask

  // One cycle: inputs change just after the rising edge, outputs are
  // observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check({"drain_", tag}, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    int x0;
    int r0;
    logic [7:0] seq [5];

    n_checks = 0; n_pass = 0; n_xfer = 0; rr1_cnt = 0;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    reset_nxt = 1'b1; tx_ready_nxt = 1'b1; last_xfer = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    reset_nxt = 1'b0;
    tick();

    // 1: all sources with 1-byte messages -> 0,1,2,3,0 with dead cycles
    for (int i = 0; i < NR; i++) begin
      sq[i].push_back({1'b1, 8'(8'h10 + i)});
      sb_push(i, 8'(8'h10 + i));
    end
    sq[0].push_back({1'b1, 8'h20});
    sb_push(0, 8'h20);
    seq[0] = 8'd0; seq[1] = 8'd1; seq[2] = 8'd2; seq[3] = 8'd3; seq[4] = 8'd0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c % 2 == 0) check("t1_idle_gap", 32'(grant), 32'd0);
      else            check("t1_grant_order", 32'(oh2idx(grant)), 32'(seq[c/2]));
    end
    run_until_idle("t1", 20);

    // 2: 3-byte message from source 1 not interleaved with source 2
    sq[1].push_back({1'b0, 8'h41});
    sq[1].push_back({1'b0, 8'h42});
    sq[1].push_back({1'b1, 8'h43});
    sq[2].push_back({1'b1, 8'h55});
    sb_push(1, 8'h41); sb_push(1, 8'h42); sb_push(1, 8'h43); sb_push(2, 8'h55);
    run_until_idle("t2", 30);

    // 3: tx_ready stall does not trigger the watchdog
    tx_ready_nxt = 1'b0;
    sq[0].push_back({1'b1, 8'h77});
    sb_push(0, 8'h77);
    k = 0;
    do begin tick(); k++; end while (grant != 4'b0001 && k < 10);
    check("t3_granted", 32'(grant), 32'b0001);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grant != 4'b0001 || timeout_pulse || last_xfer) bad++;
    end
    check("t3_hold_no_timeout", 32'(bad), 32'd0);
    tx_ready_nxt = 1'b1;
    run_until_idle("t3", 10);

    // 4: source 3 stalls mid-message, watchdog releases, source 0 next
    sq[3].push_back({1'b0, 8'h33});
    sq[0].push_back({1'b1, 8'h99});
    sb_push(3, 8'h33); sb_push(0, 8'h99);
    k = 0;
    do begin tick(); k++; end while (!last_xfer && k < 10);
    check("t4_first_byte", 32'(last_xfer), 32'd1);
    k = 0;
    do begin tick(); k++; end while (!timeout_pulse && k < 40);
    check("t4_wd_latency", 32'(k), 32'd17);
    check("t4_wd_grant", 32'(grant), 32'd0);
    check("t4_wd_busy", 32'(busy), 32'd0);
    tick();
    check("t4_pulse_once", 32'(timeout_pulse), 32'd0);
    check("t4_next_src0", 32'(grant), 32'b0001);
    run_until_idle("t4", 10);

    // 5: reset mid-message of source 2
    sq[2].push_back({1'b0, 8'hA1});
    sq[2].push_back({1'b0, 8'hA2});
    sq[2].push_back({1'b1, 8'hA3});
    sb_push(2, 8'hA1);
    k = 0;
    do begin tick(); k++; end while (!last_xfer && k < 10);
    check("t5_first_byte", 32'(last_xfer), 32'd1);
    sq[2].delete();
    reset_nxt = 1'b1;
    tick();
    tick();
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    reset_nxt = 1'b0;
    for (int i = 0; i < NR; i++) begin
      sq[i].push_back({1'b1, 8'(8'hC0 + i)});
      sb_push(i, 8'(8'hC0 + i));
    end
    tick();
    tick();
    check("t5_src0_first", 32'(grant), 32'b0001);
    run_until_idle("t5", 20);

    // 6: single-byte message transfers in the grant cycle
    x0 = n_xfer;
    r0 = rr1_cnt;
    sq[1].push_back({1'b1, 8'hB6});
    sb_push(1, 8'hB6);
    tick();
    check("t6_idle_first", 32'(grant), 32'd0);
    tick();
    check("t6_xfer_at_grant", 32'(last_xfer), 32'd1);
    repeat (3) tick();
    check("t6_one_xfer", 32'(n_xfer - x0), 32'd1);
    check("t6_ready_one_cycle", 32'(rr1_cnt - r0), 32'd1);
    check("t6_idle_after", 32'(busy), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
